spi_stream_frame_sequencer: RTL and testbench

Frame sequencer that sits in the `dataclk` domain in front of the neural-data FIFO interface and owns its write port (`FIFO_DATA_STREAM`, `FIFO_DATA_STREAM_WEN`). On each frame trigger it emits one atomic frame into that port:

- a two-word magic header;
- a 32-bit frame counter;
- one 16-bit sample from each of `N_SRC` SPI sample sources, taken round-robin over ready/valid handshakes.

It stops starting new frames once the downstream FIFO reports overflow. A timeout inserts filler for a stalled source, so frame length on the host side is always fixed.

---
 rtl/spi_stream_frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_spi_stream_frame_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stream_frame_sequencer.sv
// Frame sequencer for the neural-data FIFO write port: magic header,
// frame counter, then one round-robin sample per source per trigger.
module spi_stream_frame_sequencer #(
   parameter int          N_SRC    = 4,
   parameter logic [15:0] MAGIC_LO = 16'h1999,
   parameter logic [15:0] MAGIC_HI = 16'hC691,
   parameter int          TIMEOUT  = 255
) (
   input  logic                 dataclk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 frame_start,
   input  logic                 clear_flags,
   input  logic                 fifo_overflow,
   input  logic [16*N_SRC-1:0]  src_data,
   input  logic [N_SRC-1:0]     src_valid,
   output logic [N_SRC-1:0]     src_ready,
   output logic [15:0]          FIFO_DATA_STREAM,
   output logic                 FIFO_DATA_STREAM_WEN,
   output logic [31:0]          frame_count,
   output logic                 busy,
   output logic                 frame_missed,
   output logic [N_SRC-1:0]     src_timeout
);

   localparam int          IW       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N_SRC - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [15:0] TMO      = 16'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      HDR1,
      CNT0,
      CNT1,
      SRC
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [15:0]       timer_q, timer_d;
   logic [31:0]       snap_q, snap_d;
   logic [15:0]       data_q, data_d;
   logic              wen_q, wen_d;
   logic [31:0]       frame_cnt_q;
   logic              cnt_inc;
   logic              miss_q, miss_d;
   logic [N_SRC-1:0]  tmo_q, tmo_d, tmo_set;
   logic [15:0]       sel_data;
   logic              sel_valid;
   logic              start;

   assign start = (state_q == IDLE) & frame_start & enable & ~fifo_overflow;

   // Slot owner mux: only the current slot sees ready.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      src_ready = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (idx_q == IW'(i)) begin
            sel_data     = src_data[16*i +: 16];
            sel_valid    = src_valid[i];
            src_ready[i] = (state_q == SRC);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      snap_d  = snap_q;
      data_d  = data_q;
      wen_d   = 1'b0;
      cnt_inc = 1'b0;
      tmo_set = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               data_d  = MAGIC_LO;
               wen_d   = 1'b1;
               snap_d  = frame_cnt_q;
               state_d = HDR1;
            end
         end
         HDR1: begin
            data_d  = MAGIC_HI;
            wen_d   = 1'b1;
            state_d = CNT0;
         end
         CNT0: begin
            data_d  = snap_q[15:0];
            wen_d   = 1'b1;
            state_d = CNT1;
         end
         CNT1: begin
            data_d  = snap_q[31:16];
            wen_d   = 1'b1;
            idx_d   = '0;
            timer_d = '0;
            state_d = SRC;
         end
         SRC: begin
            // Valid data wins over filler on the timeout edge.
            if (sel_valid || (timer_q == TMO)) begin
               data_d  = sel_valid ? sel_data : 16'h0000;
               wen_d   = 1'b1;
               timer_d = '0;
               if (!sel_valid) begin
                  tmo_set = N_SRC'(1) << idx_q;
               end
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  cnt_inc = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      miss_d = (frame_start & ((state_q != IDLE) | (enable & fifo_overflow)))
             | (miss_q & ~clear_flags);
      tmo_d  = tmo_set | (tmo_q & ~{N_SRC{clear_flags}});
   end

   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         timer_q <= '0;
         snap_q  <= '0;
         data_q  <= '0;
         wen_q   <= 1'b0;
         miss_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
         snap_q  <= snap_d;
         data_q  <= data_d;
         wen_q   <= wen_d;
         miss_q  <= miss_d;
         tmo_q   <= tmo_d;
      end
   end

   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= '0;
      end else if (cnt_inc) begin
         frame_cnt_q <= frame_cnt_q + 32'd1;
      end
   end

   assign FIFO_DATA_STREAM     = data_q;
   assign FIFO_DATA_STREAM_WEN = wen_q;
   assign frame_count          = frame_cnt_q;
   assign busy                 = (state_q != IDLE);
   assign frame_missed         = miss_q;
   assign src_timeout          = tmo_q;

endmodule

// File: tb/tb_spi_stream_frame_sequencer.sv
// Directed bench for spi_stream_frame_sequencer: vector table for the
// basic frame, hand sequences for stalls, misses, wrap and reset.
module tb_spi_stream_frame_sequencer;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        frame_start;
   logic        clear_flags;
   logic        fifo_overflow;
   logic [63:0] src_data;
   logic [3:0]  src_valid;
   logic [3:0]  rdy;
   logic [15:0] data;
   logic        wen;
   logic [31:0] fcnt;
   logic        busy;
   logic        missed;
   logic [3:0]  tmo;

   int passed = 0;
   int total  = 0;

   logic [15:0] words[$];
   int          cycs[$];

   typedef struct {
      logic        fs;
      logic [3:0]  vld;
      logic        ew;
      logic [15:0] ed;
      logic        eb;
      logic [3:0]  er;
   } vec_t;

   vec_t tbl[9];

   spi_stream_frame_sequencer #(
      .N_SRC   (4),
      .MAGIC_LO(16'h1999),
      .MAGIC_HI(16'hC691),
      .TIMEOUT (5)
   ) dut (
      .dataclk             (clk),
      .reset_n             (rst_n),
      .enable              (enable),
      .frame_start         (frame_start),
      .clear_flags         (clear_flags),
      .fifo_overflow       (fifo_overflow),
      .src_data            (src_data),
      .src_valid           (src_valid),
      .src_ready           (rdy),
      .FIFO_DATA_STREAM    (data),
      .FIFO_DATA_STREAM_WEN(wen),
      .frame_count         (fcnt),
      .busy                (busy),
      .frame_missed        (missed),
      .src_timeout         (tmo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, expv);
   endfunction

   task automatic chk_zero(input string nm);
      chk({nm, "_wen"}, 32'(wen), 0);
      chk({nm, "_data"}, 32'(data), 0);
      chk({nm, "_cnt"}, fcnt, 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_miss"}, 32'(missed), 0);
      chk({nm, "_tmo"}, 32'(tmo), 0);
      chk({nm, "_rdy"}, 32'(rdy), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      frame_start   = 1'b0;
      clear_flags   = 1'b0;
      fifo_overflow = 1'b0;
      enable        = 1'b1;
      src_valid     = 4'hF;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_flags = 1'b1;
      @(posedge clk);
      #1;
      clear_flags = 1'b0;
   endtask

   // Trigger one frame and capture every WEN word with its edge index.
   task automatic collect(input int v2_cyc, input int fs2_cyc);
      bit done;
      done = 1'b0;
      words.delete();
      cycs.delete();
      @(negedge clk);
      frame_start = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c == v2_cyc) src_valid[2] = 1'b1;
         if (c == fs2_cyc) frame_start = 1'b1;
         @(posedge clk);
         #1;
         if (wen) begin
            words.push_back(data);
            cycs.push_back(c);
         end
         if (!busy) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
         frame_start = 1'b0;
      end
      frame_start = 1'b0;
      chk("frame_end", 32'(done), 1);
   endtask

   task automatic chk_frame(input string nm, input logic [31:0] cnt,
                            input logic [15:0] s2);
      logic [15:0] ew[8];
      ew = '{16'h1999, 16'hC691, cnt[15:0], cnt[31:16],
             16'h0A00, 16'h0A01, s2, 16'h0A03};
      chk({nm, "_len"}, 32'(words.size()), 8);
      for (int i = 0; i < 8 && i < words.size(); i++)
         chk($sformatf("%s_w%0d", nm, i), 32'(words[i]), 32'(ew[i]));
   endtask

   task automatic chk_cyc(input string nm, input int i, input int c);
      if (cycs.size() > i) chk(nm, 32'(cycs[i]), 32'(c));
      else chk(nm, 32'hFFFF_FFFF, 32'(c));
   endtask

   initial begin
      rst_n         = 1'b0;
      enable        = 1'b1;
      frame_start   = 1'b0;
      clear_flags   = 1'b0;
      fifo_overflow = 1'b0;
      src_valid     = 4'hF;
      for (int i = 0; i < 4; i++) src_data[16*i +: 16] = 16'(16'h0A00 + i);

      tbl[0] = '{1'b1, 4'hF, 1'b1, 16'h1999, 1'b1, 4'h0};
      tbl[1] = '{1'b0, 4'hF, 1'b1, 16'hC691, 1'b1, 4'h0};
      tbl[2] = '{1'b0, 4'hF, 1'b1, 16'h0000, 1'b1, 4'h0};
      tbl[3] = '{1'b0, 4'hF, 1'b1, 16'h0000, 1'b1, 4'h1};
      tbl[4] = '{1'b0, 4'hF, 1'b1, 16'h0A00, 1'b1, 4'h2};
      tbl[5] = '{1'b0, 4'hF, 1'b1, 16'h0A01, 1'b1, 4'h4};
      tbl[6] = '{1'b0, 4'hF, 1'b1, 16'h0A02, 1'b1, 4'h8};
      tbl[7] = '{1'b0, 4'hF, 1'b1, 16'h0A03, 1'b0, 4'h0};
      tbl[8] = '{1'b0, 4'hF, 1'b0, 16'h0000, 1'b0, 4'h0};

      #3;
      chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 9; r++) begin
         @(negedge clk);
         frame_start = tbl[r].fs;
         src_valid   = tbl[r].vld;
         @(posedge clk);
         #1;
         chk($sformatf("basic_wen%0d", r), 32'(wen), 32'(tbl[r].ew));
         if (tbl[r].ew)
            chk($sformatf("basic_data%0d", r), 32'(data), 32'(tbl[r].ed));
         chk($sformatf("basic_busy%0d", r), 32'(busy), 32'(tbl[r].eb));
         chk($sformatf("basic_rdy%0d", r), 32'(rdy), 32'(tbl[r].er));
      end
      chk("basic_cnt", fcnt, 1);

      do_reset();
      for (int f = 0; f < 3; f++) begin
         collect(-1, -1);
         chk_frame($sformatf("b2b%0d", f), 32'(f), 16'h0A02);
         chk_cyc($sformatf("b2b%0d_last", f), 7, 7);
      end
      chk("b2b_miss", 32'(missed), 0);
      chk("b2b_cnt", fcnt, 3);

      do_reset();
      src_valid = 4'b1011;
      collect(-1, -1);
      chk_frame("stall", 0, 16'h0000);
      chk_cyc("stall_fill_edge", 6, 11);
      chk("stall_tmo", 32'(tmo), 32'h4);
      chk("stall_cnt", fcnt, 1);
      pulse_clear();
      chk("stall_clear", 32'(tmo), 0);

      collect(11, -1);
      chk_frame("race", 1, 16'h0A02);
      chk_cyc("race_edge", 6, 11);
      chk("race_tmo", 32'(tmo), 0);

      src_valid = 4'b1011;
      collect(-1, 5);
      chk_frame("busymiss", 2, 16'h0000);
      chk("busymiss_flag", 32'(missed), 1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("busymiss_idle%0d", k), 32'({wen, busy}), 0);
      end
      chk("busymiss_cnt", fcnt, 3);
      pulse_clear();
      chk("busymiss_clear", 32'({missed, tmo}), 0);

      src_valid = 4'hF;
      @(negedge clk);
      fifo_overflow = 1'b1;
      frame_start   = 1'b1;
      @(posedge clk);
      #1;
      chk("ovf_wen", 32'(wen), 0);
      chk("ovf_busy", 32'(busy), 0);
      chk("ovf_miss", 32'(missed), 1);
      @(negedge clk);
      frame_start = 1'b0;
      @(posedge clk);
      #1;
      chk("ovf_wen2", 32'(wen), 0);
      @(negedge clk);
      fifo_overflow = 1'b0;
      pulse_clear();
      chk("ovf_clear", 32'(missed), 0);

      @(negedge clk);
      enable      = 1'b0;
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      chk("dis_wen", 32'(wen), 0);
      chk("dis_miss", 32'(missed), 0);
      @(negedge clk);
      frame_start = 1'b0;
      enable      = 1'b1;

      @(negedge clk);
      frame_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      frame_start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("mid_pre_wen", 32'(wen), 1);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(posedge clk);
      #1;
      chk("midrst_hold", 32'({wen, busy}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      collect(-1, -1);
      chk_frame("postrst", 0, 16'h0A02);

      @(negedge clk);
      force dut.frame_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.frame_cnt_q;
      chk("wrap_preset", fcnt, 32'hFFFF_FFFF);
      collect(-1, -1);
      chk_frame("wrap", 32'hFFFF_FFFF, 16'h0A02);
      chk("wrap_cnt", fcnt, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
